// File: rtl/mod503_residue_accumulator_if.sv
// Residue stream in / result out bundle between the LUT bank, the accumulator and the datapath consumer.
// The accumulator takes the slave side; the upstream/consumer stand-in takes the master side.
interface mod503_residue_accumulator_if #(
  parameter int RES_W = 9,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_trunc;
  logic             err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_trunc, err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_trunc, err
  );
endinterface

// File: rtl/mod503_residue_accumulator.sv
// Running mod-MODULUS sum of per-digit LUT residues; result valid one cycle after the last beat, held until taken.
// Optional MOD503_RANGE_CHECK_EN: flags and pre-reduces beats >= MODULUS via a sticky err.
module mod503_residue_accumulator #(
  parameter int MODULUS   = 503,
  parameter int RES_W     = 9,
  parameter int MAX_TERMS = 50,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst_n,
  mod503_residue_accumulator_if.slave bus
);

  localparam logic [RES_W:0]   MOD_X = (RES_W+1)'(MODULUS);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_TERMS);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_trunc_q, out_trunc_d;
  logic             in_ready_s;
  logic             out_valid_s;

  logic [RES_W-1:0] in_eff;
  logic [RES_W:0]   sum;
  logic [RES_W-1:0] red;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat_acc;
  logic             finish;

`ifdef MOD503_RANGE_CHECK_EN
  logic in_over;
  logic err_q, err_d;

  assign in_over = ({1'b0, bus.in_data} >= MOD_X);
  assign in_eff  = in_over ? RES_W'({1'b0, bus.in_data} - MOD_X) : bus.in_data;
  assign err_d   = err_q | (beat_acc & in_over);
  assign bus.err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign in_eff  = bus.in_data;
  assign bus.err = 1'b0;
`endif

  // Both operands are < MODULUS, so one conditional subtract fully reduces the sum.
  assign sum      = {1'b0, acc_q} + {1'b0, in_eff};
  assign red      = RES_W'((sum >= MOD_X) ? (sum - MOD_X) : sum);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign beat_acc = bus.in_valid & in_ready_s;
  assign finish   = beat_acc & (bus.in_last | (cnt_inc == MAX_T));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: if (beat_acc) state_d = finish ? S_HOLD : S_ACC;
      S_HOLD:        if (bus.out_ready) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_trunc_d = out_trunc_q;
    if (finish) begin
      out_data_d  = red;
      out_cnt_d   = cnt_inc;
      out_trunc_d = ~bus.in_last;
    end else if (beat_acc) begin
      acc_d = red;
      cnt_d = cnt_inc;
    end else if ((state_q == S_HOLD) && bus.out_ready) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    in_ready_s  = (state_q != S_HOLD);
    out_valid_s = (state_q == S_HOLD);
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_mod503_residue_accumulator.sv
// Scoreboarded bench for mod503_residue_accumulator: directed operands, backpressure, truncation, mid-operand reset.
module tb_mod503_residue_accumulator;

  typedef struct packed {
    logic [8:0] data;
    logic [5:0] cnt;
    logic       trunc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   acc_m  = 0;
  int   cnt_m  = 0;
  exp_t exp_q[$];

  mod503_residue_accumulator_if #(.RES_W(9), .CNT_W(6)) bus ();

  mod503_residue_accumulator #(
    .MODULUS(503), .RES_W(9), .MAX_TERMS(50), .CNT_W(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge sees what the next posedge will sample.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%0d cnt=%0d trunc=%0d, no result expected",
                 bus.out_data, bus.out_cnt, bus.out_trunc);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_data, bus.out_cnt, bus.out_trunc} !== e) begin
          errors++;
          $display("FAIL sb_result: got data=%0d cnt=%0d trunc=%0d, want data=%0d cnt=%0d trunc=%0d",
                   bus.out_data, bus.out_cnt, bus.out_trunc, e.data, e.cnt, e.trunc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int d, input bit last);
    int   n = 0;
    int   dd;
    int   s;
    exp_t e;
    logic [31:0] dv;
    dv = d;
    bus.in_valid = 1'b1;
    bus.in_data  = dv[8:0];
    bus.in_last  = last;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0d, want 1 within 20 cycles", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    dd = d;
`ifdef MOD503_RANGE_CHECK_EN
    if (dd >= 503) dd = dd - 503;
`endif
    s = acc_m + dd;
    if (s >= 503) s = s - 503;
    cnt_m++;
    if (last || cnt_m == 50) begin
      e.data  = 9'(s);
      e.cnt   = 6'(cnt_m);
      e.trunc = !last;
      exp_q.push_back(e);
      acc_m = 0;
      cnt_m = 0;
    end else begin
      acc_m = s;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc, bus.err} !== {1'b1, 1'b0, 9'd0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0d vld=%0d data=%0d cnt=%0d trunc=%0d err=%0d, want 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc, bus.err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send(300, 1'b1);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_cnt, bus.out_trunc} !== {1'b1, 1'b0, 9'd300, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_beat: vld=%0d rdy=%0d data=%0d cnt=%0d trunc=%0d, want 1 0 300 1 0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_cnt, bus.out_trunc);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    send(502, 1'b0);
    send(502, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_cnt} !== {1'b1, 9'd501, 6'd2}) begin
      errors++;
      $display("FAIL wrap_max: vld=%0d data=%0d cnt=%0d, want 1 501 2", bus.out_valid, bus.out_data, bus.out_cnt);
    end
    wait_drain();
    send(250, 1'b0);
    send(253, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_cnt} !== {1'b1, 9'd0, 6'd2}) begin
      errors++;
      $display("FAIL wrap_zero: vld=%0d data=%0d cnt=%0d, want 1 0 2", bus.out_valid, bus.out_data, bus.out_cnt);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(123, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, 9'd123}) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%0d rdy=%0d data=%0d, want 1 0 123", i, bus.out_valid, bus.in_ready, bus.out_data);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%0d rdy=%0d, want 0 1", bus.out_valid, bus.in_ready);
    end
    wait_drain();
  endtask

  task automatic test_trunc();
    for (int i = 0; i < 50; i++) send(1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc} !== {1'b1, 9'd50, 6'd50, 1'b1}) begin
      errors++;
      $display("FAIL trunc_50: vld=%0d data=%0d cnt=%0d trunc=%0d, want 1 50 50 1",
               bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc);
    end
    wait_drain();
    send(5, 1'b1);
    checks++;
    if ({bus.out_data, bus.out_cnt, bus.out_trunc} !== {9'd5, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL trunc_next: data=%0d cnt=%0d trunc=%0d, want 5 1 0", bus.out_data, bus.out_cnt, bus.out_trunc);
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) send(400, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc, bus.err} !== {1'b1, 1'b0, 9'd0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0d vld=%0d data=%0d cnt=%0d trunc=%0d err=%0d, want 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_cnt, bus.out_trunc, bus.err);
    end
    acc_m = 0;
    cnt_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(10, 1'b1);
    checks++;
    if ({bus.out_data, bus.out_cnt} !== {9'd10, 6'd1}) begin
      errors++;
      $display("FAIL post_reset: data=%0d cnt=%0d, want 10 1", bus.out_data, bus.out_cnt);
    end
    wait_drain();
  endtask

  task automatic test_range();
`ifdef MOD503_RANGE_CHECK_EN
    send(510, 1'b1);
    checks++;
    if ({bus.out_data, bus.err} !== {9'd7, 1'b1}) begin
      errors++;
      $display("FAIL range_flag: data=%0d err=%0d, want 7 1", bus.out_data, bus.err);
    end
    wait_drain();
    send(20, 1'b1);
    checks++;
    if ({bus.out_data, bus.err} !== {9'd20, 1'b1}) begin
      errors++;
      $display("FAIL range_sticky: data=%0d err=%0d, want 20 1", bus.out_data, bus.err);
    end
    wait_drain();
`else
    send(502, 1'b0);
    send(1, 1'b1);
    checks++;
    if ({bus.out_data, bus.err} !== {9'd0, 1'b0}) begin
      errors++;
      $display("FAIL range_off: data=%0d err=%0d, want 0 0", bus.out_data, bus.err);
    end
    wait_drain();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_trunc();
    test_mid_reset();
    test_range();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod503_residue_accumulator.md
Name: mod503_residue_accumulator

Overview:
Sequential stage directly downstream of the 6-input residue LUT bank (one LUT per 6-bit digit of a 300-bit operand, each producing a 9-bit residue mod 503).
Accepts one LUT residue per beat over a valid/ready stream and keeps a running sum reduced mod MODULUS.
On the last beat it presents the final residue of the whole operand on a valid/ready output.
Feeds the modular-arithmetic datapath consumer.

Parameters:
MODULUS, 503, modulus; must satisfy 2 <= MODULUS < 2**RES_W
RES_W, 9, residue width in bits
MAX_TERMS, 50, maximum beats per operand (300 bits / 6-bit digits)
CNT_W, 6, width of beat counter; must hold MAX_TERMS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  residue beat valid
in_ready  out  1  accumulator can accept a beat
in_data  in  RES_W  LUT residue; nominally < MODULUS
in_last  in  1  final beat of the operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  RES_W  (sum of all beats) mod MODULUS
out_cnt  out  CNT_W  number of beats accumulated
out_trunc  out  1  operand cut at MAX_TERMS without in_last
err  out  1  sticky range error; tied 0 when the optional feature is absent

Behaviour:
- Reset: one clock, asynchronous active-low reset, rst_n. While rst_n=0 the block forces:
  - state=IDLE, acc=0, cnt=0
  - in_ready=1, out_valid=0, out_data=0, out_cnt=0, out_trunc=0, err=0
- Reset may assert mid-operand or mid-HOLD. The partial sum and any pending result are discarded, with no output beat.
- States:
  - IDLE: acc=0, cnt=0.
  - ACC: mid-operand.
  - HOLD: result presented.
- in_ready=1 in IDLE and ACC; in_ready=0 in HOLD. There is no overlap of new input with a pending result.
- Beat accepted when in_valid&in_ready.
  - s = acc + in_data, computed at RES_W+1 bits.
  - r = s - MODULUS if s >= MODULUS, else s. Single conditional subtract.
  - cnt increments by 1.
- Accepted beat with in_last=0 and cnt+1 < MAX_TERMS: acc <= r, state <= ACC.
- Accepted beat with in_last=1: out_data <= r, out_cnt <= cnt+1, out_trunc <= 0, state <= HOLD.
- Accepted beat with in_last=0 and cnt+1 == MAX_TERMS: treated as last, and out_trunc <= 1.
- Latency: out_valid rises the cycle after the final beat is accepted.
- out_valid=1 exactly in HOLD. out_data, out_cnt and out_trunc stay stable while out_valid=1 and out_ready=0.
- HOLD with out_ready=1: state <= IDLE, acc <= 0, cnt <= 0, out_valid <= 0. in_ready returns to 1 the following cycle.
- A single-beat operand (first beat with in_last=1) goes IDLE->HOLD directly.
- in_valid=0 in ACC: hold all state indefinitely, no timeout.
- With MODULUS=503: acc max 502, in max 502, s max 1004, so r = 501 fits in RES_W.
- out_data is always < MODULUS when every input is < MODULUS.

Optional Feature:
- Macro: MOD503_RANGE_CHECK_EN.
- Defined:
  - An accepted beat with in_data >= MODULUS sets err <= 1.
  - err is sticky until reset.
  - That beat first reduces in_data by one conditional subtract of MODULUS, then accumulates as normal.
- Undefined:
  - No check and no pre-reduction; err is constant 0.
  - Out-of-range inputs give undefined-but-bounded results (RES_W-bit wrap of r).

Test Plan:
- Single beat in_data=300, in_last=1 -> next cycle out_valid=1, out_data=300, out_cnt=1, out_trunc=0.
- Beats 502, 502 (last) -> out_data=501, out_cnt=2. Beats 250, 253 (last) -> out_data=0.
- Backpressure: result 123 pending, out_ready=0 for 5 cycles -> out_data stable at 123, in_ready=0 throughout. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- 50 beats of value 1, in_last never set -> after beat 50: out_data=50, out_cnt=50, out_trunc=1. Next operand starts from acc=0.
- rst_n pulsed low after 3 beats of 400 -> all outputs at reset values. New operand 10 (last) -> out_data=10, out_cnt=1.
- With MOD503_RANGE_CHECK_EN: beat 510 (last) -> out_data=7, err=1, err remains 1 on subsequent operands. Without the macro: err=0 throughout.
